ram_arbiter: RTL and testbench

- Sits between zerocore and the RAMHelper in SimTop.
- Shares the single RAMHelper read/write port between two requesters: instruction fetch (IF, read-only) and load/store (MEM, read/write).
- Sequences each access through a small FSM, converts byte addresses to RAM word indices, generates lane masks/shifts, and returns responses over valid/ready handshakes.

---
 rtl/zero_mem_pkg.sv | 38 +++
 rtl/ram_arbiter_if.sv | 49 ++++
 rtl/mem_lane_align.sv | 31 +++
 rtl/ram_arbiter.sv | 171 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/zero_mem_pkg.sv
// rtl/zero_mem_pkg.sv - shared types and constants for the RAM arbiter
package zero_mem_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam logic [ADDR_W-1:0] RAM_BASE_DEFAULT = 64'h8000_0000;
    localparam int MAX_MEM_STREAK_DEFAULT = 4;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_IF  = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

    // Right-aligned byte-lane mask covering one access of the given size
    function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  size_mask = 64'h0000_0000_0000_00FF;
            SIZE_H:  size_mask = 64'h0000_0000_0000_FFFF;
            SIZE_W:  size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = '1;
        endcase
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester and RAMHelper signal bundle for the arbiter
interface ram_arbiter_if;
    import zero_mem_pkg::*;

    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_resp_valid;
    logic              if_resp_ready;
    logic [31:0]       if_resp_inst;
    logic              if_resp_err;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_wen;
    logic [1:0]        mem_req_size;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_valid;
    logic              mem_resp_ready;
    logic [DATA_W-1:0] mem_resp_rdata;
    logic              mem_resp_err;

    logic              ram_ren;
    logic [ADDR_W-1:0] ram_ridx;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_widx;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_wmask;

    modport slave (
        input  if_req_valid, if_req_addr, if_resp_ready,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_size, mem_req_wdata, mem_resp_ready,
        input  ram_rdata,
        output if_req_ready, if_resp_valid, if_resp_inst, if_resp_err,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
        output ram_ren, ram_ridx, ram_wen, ram_widx, ram_wdata, ram_wmask
    );

    modport master (
        output if_req_valid, if_req_addr, if_resp_ready,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_size, mem_req_wdata, mem_resp_ready,
        output ram_rdata,
        input  if_req_ready, if_resp_valid, if_resp_inst, if_resp_err,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
        input  ram_ren, ram_ridx, ram_wen, ram_widx, ram_wdata, ram_wmask
    );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane mask, store shift, load extract and misalign check
module mem_lane_align
    import zero_mem_pkg::*;
(
    input  logic [2:0]        addr_lo_i,
    input  logic [1:0]        size_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] wmask_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              misalign_o
);
    logic [5:0]        shamt;
    logic [DATA_W-1:0] smask;

    // Lane position is the byte offset inside the 8-byte RAM word
    always_comb begin
        shamt   = {addr_lo_i, 3'b000};
        smask   = size_mask(size_i);
        wmask_o = smask << shamt;
        wdata_o = wdata_i << shamt;
        rdata_o = (rdata_i >> shamt) & smask;
        case (size_i)
            SIZE_B:  misalign_o = 1'b0;
            SIZE_H:  misalign_o = addr_lo_i[0];
            SIZE_W:  misalign_o = |addr_lo_i[1:0];
            default: misalign_o = |addr_lo_i;
        endcase
    end
endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares the RAMHelper port between instruction fetch and load/store
module ram_arbiter
    import zero_mem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RAM_BASE       = RAM_BASE_DEFAULT,
    parameter int                MAX_MEM_STREAK = MAX_MEM_STREAK_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave bus
);
    localparam int STREAK_W = $clog2(MAX_MEM_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_MEM_STREAK);

    arb_state_e          state_q;
    req_id_e             owner_q;
    logic [2:0]          addr_lo_q;
    logic [1:0]          size_q;
    logic                wen_q;
    logic [STREAK_W-1:0] streak_q;

    logic              ram_ren_q, ram_wen_q;
    logic [ADDR_W-1:0] ram_ridx_q, ram_widx_q;
    logic [DATA_W-1:0] ram_wdata_q, ram_wmask_q;
    logic              if_resp_valid_q, if_resp_err_q;
    logic [31:0]       if_resp_inst_q;
    logic              mem_resp_valid_q, mem_resp_err_q;
    logic [DATA_W-1:0] mem_resp_rdata_q;

    logic              grant_if, grant_mem, in_idle;
    logic [ADDR_W-1:0] acc_addr, acc_idx;
    logic [1:0]        acc_size;
    logic              acc_wen;
    logic [2:0]        la_addr_lo;
    logic [1:0]        la_size;
    logic [DATA_W-1:0] la_wmask, la_wdata, la_rdata;
    logic              la_misalign;

    // Grant selection and accept-time request decode; lane unit sees the live request in IDLE, the latched one afterwards
    always_comb begin
        grant_mem  = bus.mem_req_valid && (!bus.if_req_valid || streak_q != STREAK_MAX);
        grant_if   = bus.if_req_valid && !grant_mem;
        in_idle    = (state_q == ST_IDLE) && !rst;
        acc_addr   = grant_mem ? bus.mem_req_addr : bus.if_req_addr;
        acc_size   = grant_mem ? bus.mem_req_size : SIZE_W;
        acc_wen    = grant_mem && bus.mem_req_wen;
        acc_idx    = (acc_addr - RAM_BASE) >> 3;
        la_addr_lo = in_idle ? acc_addr[2:0] : addr_lo_q;
        la_size    = in_idle ? acc_size : size_q;
    end

    mem_lane_align u_align (
        .addr_lo_i  (la_addr_lo),
        .size_i     (la_size),
        .wdata_i    (bus.mem_req_wdata),
        .rdata_i    (bus.ram_rdata),
        .wmask_o    (la_wmask),
        .wdata_o    (la_wdata),
        .rdata_o    (la_rdata),
        .misalign_o (la_misalign)
    );

    assign bus.if_req_ready   = in_idle && grant_if;
    assign bus.mem_req_ready  = in_idle && grant_mem;
    assign bus.ram_ren        = ram_ren_q;
    assign bus.ram_wen        = ram_wen_q;
    assign bus.ram_ridx       = ram_ridx_q;
    assign bus.ram_widx       = ram_widx_q;
    assign bus.ram_wdata      = ram_wdata_q;
    assign bus.ram_wmask      = ram_wmask_q;
    assign bus.if_resp_valid  = if_resp_valid_q;
    assign bus.if_resp_inst   = if_resp_inst_q;
    assign bus.if_resp_err    = if_resp_err_q;
    assign bus.mem_resp_valid = mem_resp_valid_q;
    assign bus.mem_resp_rdata = mem_resp_rdata_q;
    assign bus.mem_resp_err   = mem_resp_err_q;

    // Transaction FSM: one access at a time, RAM strobes pulse only in ACCESS
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            owner_q          <= REQ_IF;
            addr_lo_q        <= '0;
            size_q           <= '0;
            wen_q            <= 1'b0;
            streak_q         <= '0;
            ram_ren_q        <= 1'b0;
            ram_wen_q        <= 1'b0;
            ram_ridx_q       <= '0;
            ram_widx_q       <= '0;
            ram_wdata_q      <= '0;
            ram_wmask_q      <= '0;
            if_resp_valid_q  <= 1'b0;
            if_resp_inst_q   <= '0;
            if_resp_err_q    <= 1'b0;
            mem_resp_valid_q <= 1'b0;
            mem_resp_rdata_q <= '0;
            mem_resp_err_q   <= 1'b0;
        end else begin
            ram_ren_q <= 1'b0;
            ram_wen_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_if || grant_mem) begin
                        owner_q   <= grant_mem ? REQ_MEM : REQ_IF;
                        addr_lo_q <= acc_addr[2:0];
                        size_q    <= acc_size;
                        wen_q     <= acc_wen;
                        if (grant_if) begin
                            streak_q <= '0;
                        end else if (bus.if_req_valid && streak_q != STREAK_MAX) begin
                            streak_q <= streak_q + 1'b1;
                        end
                        if (la_misalign) begin
                            state_q <= ST_RESP;
                            if (grant_mem) begin
                                mem_resp_valid_q <= 1'b1;
                                mem_resp_err_q   <= 1'b1;
                                mem_resp_rdata_q <= '0;
                            end else begin
                                if_resp_valid_q <= 1'b1;
                                if_resp_err_q   <= 1'b1;
                                if_resp_inst_q  <= '0;
                            end
                        end else begin
                            state_q <= ST_ACCESS;
                            if (acc_wen) begin
                                ram_wen_q   <= 1'b1;
                                ram_widx_q  <= acc_idx;
                                ram_wdata_q <= la_wdata;
                                ram_wmask_q <= la_wmask;
                            end else begin
                                ram_ren_q  <= 1'b1;
                                ram_ridx_q <= acc_idx;
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    if (wen_q) begin
                        state_q          <= ST_RESP;
                        mem_resp_valid_q <= 1'b1;
                        mem_resp_err_q   <= 1'b0;
                        mem_resp_rdata_q <= '0;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    state_q <= ST_RESP;
                    if (owner_q == REQ_MEM) begin
                        mem_resp_valid_q <= 1'b1;
                        mem_resp_err_q   <= 1'b0;
                        mem_resp_rdata_q <= la_rdata;
                    end else begin
                        if_resp_valid_q <= 1'b1;
                        if_resp_err_q   <= 1'b0;
                        if_resp_inst_q  <= la_rdata[31:0];
                    end
                end
                default: begin
                    if ((owner_q == REQ_MEM) ? bus.mem_resp_ready : bus.if_resp_ready) begin
                        state_q          <= ST_IDLE;
                        if_resp_valid_q  <= 1'b0;
                        mem_resp_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized self-checking bench for ram_arbiter
module tb_ram_arbiter;
    import zero_mem_pkg::*;

    localparam logic [63:0] BASE = 64'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_arbiter_if bus();

    ram_arbiter #(.RAM_BASE(BASE), .MAX_MEM_STREAK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pattern(input int i);
        pattern = 64'hAAAA_BBBB_1111_2222 ^ (64'(i) * 64'h0123_4567_89AB_CDEF);
    endfunction

    // RAMHelper model: 16 words, read data one cycle after ren, byte-masked writes
    logic [63:0] ram_words [0:15];
    bit          ram_init = 1'b0;
    always @(posedge clk) begin
        logic [63:0] w;
        if (ram_init) begin
            for (int i = 0; i < 16; i++) ram_words[i] <= pattern(i);
        end else begin
            if (bus.ram_ren) bus.ram_rdata <= ram_words[bus.ram_ridx[3:0]];
            if (bus.ram_wen) begin
                w = ram_words[bus.ram_widx[3:0]];
                for (int b = 0; b < 8; b++)
                    if (bus.ram_wmask[b*8]) w[b*8 +: 8] = bus.ram_wdata[b*8 +: 8];
                ram_words[bus.ram_widx[3:0]] <= w;
            end
        end
    end

    // Reference: flat byte memory of the 128-byte window
    logic [7:0] ref_mem [0:127];

    int ren_cnt = 0;
    int wen_cnt = 0;
    always @(negedge clk) begin
        if (bus.ram_ren) ren_cnt <= ren_cnt + 1;
        if (bus.ram_wen) wen_cnt <= wen_cnt + 1;
        if (bus.ram_ren || bus.ram_wen) check("ren_wen_excl", 64'(bus.ram_ren & bus.ram_wen), 64'd0);
        if (bus.if_req_ready || bus.mem_req_ready)
            check("one_ready", 64'(bus.if_req_ready & bus.mem_req_ready), 64'd0);
    end

    task automatic do_req(input bit is_mem, input int off, input bit wen, input logic [1:0] size,
                          input logic [63:0] wdata);
        int nb, w, lat, ren0, wen0, exp_lat, lo;
        bit mis, rdy, rv;
        logic [63:0] exp_d, exp_m, exp_wd;
        nb  = is_mem ? (1 << size) : 4;
        mis = (off % nb) != 0;
        lo  = off % 8;
        exp_d = '0; exp_m = '0; exp_wd = '0;
        if (!mis) begin
            for (int b = 0; b < nb; b++) begin
                if (!wen) exp_d[b*8 +: 8] = ref_mem[off+b];
                exp_m[(lo+b)*8 +: 8]  = 8'hFF;
                exp_wd[(lo+b)*8 +: 8] = wdata[b*8 +: 8];
            end
        end
        exp_lat = mis ? 1 : (wen ? 2 : 3);

        @(negedge clk);
        if (is_mem) begin
            bus.mem_req_valid = 1'b1;
            bus.mem_req_addr  = BASE + 64'(off);
            bus.mem_req_wen   = wen;
            bus.mem_req_size  = size;
            bus.mem_req_wdata = wdata;
        end else begin
            bus.if_req_valid = 1'b1;
            bus.if_req_addr  = BASE + 64'(off);
        end
        #1;
        w = 0;
        rdy = is_mem ? bus.mem_req_ready : bus.if_req_ready;
        while (!rdy && w < 20) begin
            @(negedge clk); #1; w++;
            rdy = is_mem ? bus.mem_req_ready : bus.if_req_ready;
        end
        check("accept", 64'(rdy), 64'd1);
        ren0 = ren_cnt; wen0 = wen_cnt;
        @(posedge clk);
        @(negedge clk);
        bus.if_req_valid  = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.if_req_addr   = {$urandom, $urandom};
        bus.mem_req_addr  = {$urandom, $urandom};
        bus.mem_req_wdata = {$urandom, $urandom};
        lat = 1;
        if (!mis && wen) begin
            check("ram_wen", 64'(bus.ram_wen), 64'd1);
            check("ram_widx", bus.ram_widx, 64'(off / 8));
            check("ram_wmask", bus.ram_wmask, exp_m);
            check("ram_wdata", bus.ram_wdata & exp_m, exp_wd);
        end else if (!mis) begin
            check("ram_ren", 64'(bus.ram_ren), 64'd1);
            check("ram_ridx", bus.ram_ridx, 64'(off / 8));
        end
        rv = is_mem ? bus.mem_resp_valid : bus.if_resp_valid;
        while (!rv && lat < 8) begin
            @(negedge clk); lat++;
            rv = is_mem ? bus.mem_resp_valid : bus.if_resp_valid;
        end
        check("resp_latency", 64'(lat), 64'(exp_lat));
        if (is_mem) begin
            check("mem_rdata", bus.mem_resp_rdata, exp_d);
            check("mem_err", 64'(bus.mem_resp_err), 64'(mis));
            check("if_valid_idle", 64'(bus.if_resp_valid), 64'd0);
            bus.mem_resp_ready = 1'b1;
        end else begin
            check("if_inst", 64'(bus.if_resp_inst), exp_d);
            check("if_err", 64'(bus.if_resp_err), 64'(mis));
            check("mem_valid_idle", 64'(bus.mem_resp_valid), 64'd0);
            bus.if_resp_ready = 1'b1;
        end
        @(negedge clk);
        bus.mem_resp_ready = 1'b0;
        bus.if_resp_ready  = 1'b0;
        check("resp_drop", 64'(is_mem ? bus.mem_resp_valid : bus.if_resp_valid), 64'd0);
        check("ren_count", 64'(ren_cnt - ren0), 64'(!mis && !wen));
        check("wen_count", 64'(wen_cnt - wen0), 64'(!mis && wen));
        if (!mis && wen)
            for (int b = 0; b < nb; b++) ref_mem[off+b] = wdata[b*8 +: 8];
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int grants [0:9];
        int ng, cyc, ren0, off, nb, w;
        logic [63:0] held;
        logic [1:0] sz;
        bit im;

        rst = 1'b1;
        bus.if_req_valid = 1'b1; bus.if_req_addr = BASE; bus.if_resp_ready = 1'b0;
        bus.mem_req_valid = 1'b1; bus.mem_req_addr = BASE; bus.mem_req_wen = 1'b0;
        bus.mem_req_size = 2'd3; bus.mem_req_wdata = '0; bus.mem_resp_ready = 1'b0;
        bus.ram_rdata = '0;
        for (int i = 0; i < 16; i++)
            for (int b = 0; b < 8; b++) ref_mem[i*8+b] = pattern(i) >> (b*8);
        ram_init = 1'b1;
        repeat (3) @(negedge clk);
        ram_init = 1'b0;

        // Reset state while both requesters are valid
        check("rst_if_ready", 64'(bus.if_req_ready), 64'd0);
        check("rst_mem_ready", 64'(bus.mem_req_ready), 64'd0);
        check("rst_if_valid", 64'(bus.if_resp_valid), 64'd0);
        check("rst_mem_valid", 64'(bus.mem_resp_valid), 64'd0);
        check("rst_errs", 64'(bus.if_resp_err | bus.mem_resp_err), 64'd0);
        check("rst_strobes", 64'(bus.ram_ren | bus.ram_wen), 64'd0);
        check("rst_ridx", bus.ram_ridx, 64'd0);
        check("rst_rdata", bus.mem_resp_rdata, 64'd0);
        bus.if_req_valid = 1'b0; bus.mem_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        do_req(1'b0, 4, 1'b0, 2'd2, '0);
        do_req(1'b1, 16'h16, 1'b1, 2'd1, 64'h1234);
        do_req(1'b1, 2, 1'b0, 2'd2, '0);
        do_req(1'b1, 16'h16, 1'b0, 2'd1, '0);

        // Response held under back-pressure
        @(negedge clk);
        bus.mem_req_valid = 1'b1; bus.mem_req_addr = BASE + 64'h18;
        bus.mem_req_wen = 1'b0; bus.mem_req_size = 2'd3;
        #1; w = 0;
        while (!bus.mem_req_ready && w < 20) begin @(negedge clk); #1; w++; end
        check("hold_accept", 64'(bus.mem_req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.mem_req_valid = 1'b0;
        w = 0;
        while (!bus.mem_resp_valid && w < 8) begin @(negedge clk); w++; end
        for (int b = 0; b < 8; b++) held[b*8 +: 8] = ref_mem[8'h18 + b];
        check("hold_first", bus.mem_resp_rdata, held);
        bus.if_req_valid = 1'b1; bus.if_req_addr = BASE;
        bus.mem_req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("hold_valid", 64'(bus.mem_resp_valid), 64'd1);
            check("hold_data", bus.mem_resp_rdata, held);
            check("hold_ready", 64'(bus.if_req_ready | bus.mem_req_ready), 64'd0);
            @(negedge clk);
        end
        bus.if_req_valid = 1'b0; bus.mem_req_valid = 1'b0;
        bus.mem_resp_ready = 1'b1;
        @(negedge clk);
        bus.mem_resp_ready = 1'b0;

        // Reset during WAIT drops the transaction
        bus.mem_req_valid = 1'b1; bus.mem_req_addr = BASE + 64'h20;
        bus.mem_req_wen = 1'b0; bus.mem_req_size = 2'd3;
        #1; w = 0;
        while (!bus.mem_req_ready && w < 20) begin @(negedge clk); #1; w++; end
        check("rstw_accept", 64'(bus.mem_req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.mem_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ren0 = ren_cnt;
        for (int k = 0; k < 4; k++) begin
            check("rstw_valid", 64'(bus.mem_resp_valid | bus.if_resp_valid), 64'd0);
            @(negedge clk);
        end
        check("rstw_no_strobe", 64'(ren_cnt - ren0), 64'd0);
        do_req(1'b1, 16'h20, 1'b0, 2'd3, '0);

        // Contested arbitration from a cleared streak
        pulse_reset();
        bus.mem_req_valid = 1'b1; bus.mem_req_addr = BASE + 64'h8;
        bus.mem_req_wen = 1'b0; bus.mem_req_size = 2'd3;
        bus.if_req_valid = 1'b1; bus.if_req_addr = BASE + 64'h10;
        bus.mem_resp_ready = 1'b1; bus.if_resp_ready = 1'b1;
        ng = 0; cyc = 0;
        while (ng < 10 && cyc < 300) begin
            #1;
            if (bus.mem_req_ready) begin grants[ng] = 1; ng++; end
            else if (bus.if_req_ready) begin grants[ng] = 0; ng++; end
            @(negedge clk); cyc++;
        end
        bus.mem_req_valid = 1'b0; bus.if_req_valid = 1'b0;
        check("arb_grants", 64'(ng), 64'd10);
        for (int k = 0; k < ng; k++) check("arb_winner", 64'(grants[k]), 64'((k % 5 == 4) ? 0 : 1));
        repeat (6) @(negedge clk);
        bus.mem_resp_ready = 1'b0; bus.if_resp_ready = 1'b0;

        // Randomized traffic against the byte model
        for (int t = 0; t < 60; t++) begin
            im  = $urandom_range(0, 1) == 1;
            sz  = im ? 2'($urandom_range(0, 3)) : 2'd2;
            nb  = 1 << sz;
            off = int'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) off = off & ~(nb - 1);
            do_req(im, off, im && ($urandom_range(0, 1) == 1), sz, {$urandom, $urandom});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
